uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter (9600 baud, 1 start + 8 data + 1 stop) among NUM_REQ requesters. It grants one requester at a time and latches that requester's byte onto the transmitter data input. It issues the single-cycle start pulse, then times the frame, because the transmitter has no busy or done output. It sits between the system clients (keypad/display/command logic) and the transmitter, in the clk_9600hz domain.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Client-side bundle of the UART transmit arbiter: requests, per-requester
// handshake pulses and the transmitter drive (start pulse + data byte).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic                 enable;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic                 tx_start;
    logic [7:0]           tx_data;

    // master: the requesting clients; slave: the arbiter itself
    modport master (
        output enable, req, req_data,
        input  ack, done, busy, tx_start, tx_data
    );

    modport slave (
        input  enable, req, req_data,
        output ack, done, busy, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ clients.
// The transmitter has no busy/done, so each frame is timed with a cycle counter.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 11,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             clk_9600hz,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;

    logic [7:0]         req_byte [NUM_REQ];
    logic               win_found_d;
    logic [PTR_W-1:0]   win_idx_d;
    logic [PTR_W-1:0]   ptr_d;
    logic [7:0]         win_byte_d;
    logic               frame_end;
    logic               gap_end;
    logic               slot_free;
    logic               grant;
    int                 cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
            assign req_byte[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    // Scan from the farthest offset back to ptr so the nearest set request wins.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand        = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (bus.req[PTR_W'(cand)]) begin
                win_found_d = 1'b1;
                win_idx_d   = PTR_W'(cand);
            end
        end
    end

    assign ptr_d      = (win_idx_d == LAST_IDX) ? '0 : win_idx_d + PTR_W'(1);
    assign win_byte_d = req_byte[win_idx_d];

    assign frame_end = (state_q == SEND) && (cnt_q == FRAME_LAST);
    assign gap_end   = (state_q == GAP) && (cnt_q == GAP_LAST);

    // The edge that would return to IDLE may grant directly, so back-to-back
    // frames start exactly FRAME_CYCLES+GAP_CYCLES cycles apart.
    assign slot_free = (state_q == IDLE) || gap_end || (frame_end && (GAP_CYCLES == 0));
    assign grant     = slot_free && bus.enable && win_found_d;

    always_ff @(posedge clk_9600hz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            ack_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            if (frame_end) begin
                done_q[sel_q] <= 1'b1;
            end
            if (grant) begin
                state_q           <= SEND;
                cnt_q             <= '0;
                sel_q             <= win_idx_d;
                ptr_q             <= ptr_d;
                tx_data_q         <= win_byte_d;
                tx_start_q        <= 1'b1;
                ack_q[win_idx_d]  <= 1'b1;
                busy_q            <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                    end
                    SEND: begin
                        if (frame_end) begin
                            cnt_q <= '0;
                            if (GAP_CYCLES == 0) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= GAP;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a table of single-grant vectors walking the
// round-robin pointer, then hand sequences for bursts, fairness, enable, reset and GAP=0.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic rst0_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt [4];

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(2)) b0 ();

    uart_tx_arbiter #(.NUM_REQ(4), .FRAME_CYCLES(11), .GAP_CYCLES(1)) u_dut (
        .clk_9600hz (clk),
        .reset      (rst_n),
        .bus        (bus)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .FRAME_CYCLES(11), .GAP_CYCLES(0)) u_dut_gap0 (
        .clk_9600hz (clk),
        .reset      (rst0_n),
        .bus        (b0)
    );

    typedef struct {
        logic [3:0] req;
        int         win;
        logic [7:0] data;
    } vec_t;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (bus.done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input bit use0, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(posedge clk);
            #1;
            ok = use0 ? b0.tx_start : bus.tx_start;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [9];
        bit   ok;
        bit   flag;
        int   t_last;
        int   snap [4];
        logic [7:0] exp_b;

        tbl[0] = '{req: 4'b0001, win: 0, data: 8'hA5};
        tbl[1] = '{req: 4'b0001, win: 0, data: 8'hA5};
        tbl[2] = '{req: 4'b1001, win: 3, data: 8'h44};
        tbl[3] = '{req: 4'b1010, win: 1, data: 8'h22};
        tbl[4] = '{req: 4'b0011, win: 0, data: 8'hA5};
        tbl[5] = '{req: 4'b0100, win: 2, data: 8'h33};
        tbl[6] = '{req: 4'b0110, win: 1, data: 8'h22};
        tbl[7] = '{req: 4'b1111, win: 2, data: 8'h33};
        tbl[8] = '{req: 4'b1000, win: 3, data: 8'h44};

        rst_n        = 1'b0;
        rst0_n       = 1'b0;
        bus.enable   = 1'b1;
        bus.req      = 4'b0;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        b0.enable    = 1'b1;
        b0.req       = 2'b0;
        b0.req_data  = {8'h5A, 8'hC3};
        #12;
        check("reset_ack", bus.ack, 0);
        check("reset_done", bus.done, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_tx_start", bus.tx_start, 0);
        check("reset_tx_data", bus.tx_data, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst0_n = 1'b1;
        tick(2);

        // Table: one grant per record from IDLE, pointer carried record to record.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.req = tbl[i].req;
            tick(1);
            check($sformatf("v%0d_ack", i), bus.ack, 32'(1) << tbl[i].win);
            check($sformatf("v%0d_tx_start", i), bus.tx_start, 1);
            check($sformatf("v%0d_tx_data", i), bus.tx_data, tbl[i].data);
            check($sformatf("v%0d_busy", i), bus.busy, 1);
            bus.req = 4'b0;
            bus.req_data[8*tbl[i].win +: 8] = ~tbl[i].data;
            tick(10);
            check($sformatf("v%0d_done_early", i), bus.done, 0);
            check($sformatf("v%0d_tx_start_pulse", i), bus.tx_start, 0);
            tick(1);
            check($sformatf("v%0d_done", i), bus.done, 32'(1) << tbl[i].win);
            check($sformatf("v%0d_tx_data_hold", i), bus.tx_data, tbl[i].data);
            tick(1);
            check($sformatf("v%0d_busy_low", i), bus.busy, 0);
            check($sformatf("v%0d_done_clear", i), bus.done, 0);
            bus.req_data[8*tbl[i].win +: 8] = tbl[i].data;
        end

        // All four at once from ptr=0.
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 4; k++) snap[k] = done_cnt[k];
        t_last = 0;
        @(negedge clk);
        bus.req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_start(1'b0, 14, ok);
            check($sformatf("all_start%0d_seen", j), ok, 1);
            check($sformatf("all_ack%0d", j), bus.ack, 32'(1) << j);
            exp_b = 8'(8'h11 * (j + 1));
            check($sformatf("all_data%0d", j), bus.tx_data, exp_b);
            if (j > 0) check($sformatf("all_spacing%0d", j), cyc - t_last, 12);
            t_last = cyc;
            bus.req[j] = 1'b0;
        end
        tick(14);
        for (int k = 0; k < 4; k++) check($sformatf("all_done_count%0d", k), done_cnt[k] - snap[k], 1);
        check("all_busy_low", bus.busy, 0);

        // Fairness: req0 held, req2 arrives mid-frame.
        @(negedge clk);
        bus.req = 4'b0001;
        wait_start(1'b0, 2, ok);
        check("fair_first_seen", ok, 1);
        check("fair_first_ack", bus.ack, 4'b0001);
        t_last = cyc;
        tick(3);
        bus.req[2] = 1'b1;
        wait_start(1'b0, 14, ok);
        check("fair_second_seen", ok, 1);
        check("fair_second_ack", bus.ack, 4'b0100);
        check("fair_second_spacing", cyc - t_last, 12);
        t_last = cyc;
        bus.req[2] = 1'b0;
        wait_start(1'b0, 14, ok);
        check("fair_third_seen", ok, 1);
        check("fair_third_ack", bus.ack, 4'b0001);
        check("fair_third_spacing", cyc - t_last, 12);
        bus.req[0] = 1'b0;
        tick(14);

        // enable dropped in cycle 3 of a frame; ptr=1 here.
        @(negedge clk);
        bus.req = 4'b0010;
        wait_start(1'b0, 2, ok);
        check("en_grant_ack", bus.ack, 4'b0010);
        bus.req = 4'b1000;
        tick(2);
        bus.enable = 1'b0;
        tick(9);
        check("en_done", bus.done, 4'b0010);
        flag = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (bus.ack != 4'b0 || bus.tx_start) flag = 1'b1;
        end
        check("en_no_grant", flag, 0);
        check("en_busy_low", bus.busy, 0);
        @(negedge clk);
        bus.enable = 1'b1;
        tick(1);
        check("en_resume_ack", bus.ack, 4'b1000);
        check("en_resume_start", bus.tx_start, 1);
        bus.req = 4'b0;
        tick(14);

        // Async reset at cycle 5 of SEND; ptr=0 here, so req2 wins and ptr moves to 3.
        @(negedge clk);
        bus.req = 4'b0100;
        wait_start(1'b0, 2, ok);
        check("rst_grant_ack", bus.ack, 4'b0100);
        bus.req = 4'b1010;
        snap[2] = done_cnt[2];
        tick(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_done", bus.done, 0);
        check("rst_tx_data", bus.tx_data, 0);
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("rst_regrant_ack", bus.ack, 4'b0010);
        check("rst_regrant_data", bus.tx_data, 8'h22);
        bus.req = 4'b1000;
        wait_start(1'b0, 14, ok);
        check("rst_next_ack", bus.ack, 4'b1000);
        bus.req = 4'b0;
        tick(14);
        check("rst_no_done2", done_cnt[2] - snap[2], 0);

        // GAP_CYCLES=0 build: back-to-back starts 11 cycles apart.
        @(negedge clk);
        b0.req = 2'b11;
        wait_start(1'b1, 2, ok);
        check("g0_first_seen", ok, 1);
        check("g0_first_ack", b0.ack, 2'b01);
        check("g0_first_data", b0.tx_data, 8'hC3);
        t_last = cyc;
        b0.req[0] = 1'b0;
        wait_start(1'b1, 14, ok);
        check("g0_second_seen", ok, 1);
        check("g0_second_ack", b0.ack, 2'b10);
        check("g0_second_data", b0.tx_data, 8'h5A);
        check("g0_spacing", cyc - t_last, 11);
        check("g0_done0", b0.done, 2'b01);
        check("g0_busy_held", b0.busy, 1);
        b0.req = 2'b0;
        tick(11);
        check("g0_done1", b0.done, 2'b10);
        check("g0_busy_low", b0.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
